// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RV32I core: owns the PC, drives instruction memory,
// and registers the returned word into IF/ID with stall, redirect and halt handling.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0063,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_HALTED
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        halted_q, halted_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] redirect_target;
    logic        fetched_halt;

    // Low two bits of the redirect target are dropped to keep the PC word-aligned.
    assign redirect_target = redirect_pc & ~32'h0000_0003;
    assign fetched_halt    = (imem_instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= NOP_INSTR;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            S_RUN: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end else if (!stall) begin
                    if_pc_d       = pc_q;
                    if_instr_d    = imem_instr;
                    if_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    // A fetched halt parks the PC on itself until decode takes it.
                    if (fetched_halt) begin
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_target;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = S_RUN;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    halted_d   = 1'b1;
                    state_d    = S_HALTED;
                end
            end
            S_HALTED: begin
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule
